// File: rtl/axil_reg_wr_queue.sv
// AXI-Lite write slave that queues AW and W beats and replays them one at a time
// onto a simple register write port, returning OKAY / SLVERR (timeout) / DECERR.

module axil_reg_wr_queue_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module axil_reg_wr_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    AW_DEPTH   = 4,
    parameter int                    W_DEPTH    = 4,
    parameter int                    TIMEOUT    = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    output logic [ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic [STRB_WIDTH-1:0] reg_wr_strb,
    output logic                  reg_wr_en,
    input  logic                  reg_wr_wait,
    input  logic                  reg_wr_ack,
    output logic                  stat_timeout,
    output logic                  stat_decerr
);
    localparam int                CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0] bresp_next;
    logic       timeout_next, decerr_next;
    logic       pop;

    logic                  aw_full, aw_empty, w_full, w_empty;
    logic [ADDR_WIDTH-1:0] aw_head;

    logic unused;
    assign unused = ^s_axil_awprot;

    assign s_axil_awready = !aw_full && !rst;
    assign s_axil_wready  = !w_full && !rst;

    axil_reg_wr_queue_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_axil_awvalid && s_axil_awready),
        .push_data (s_axil_awaddr),
        .pop       (pop),
        .head      (aw_head),
        .full      (aw_full),
        .empty     (aw_empty)
    );

    axil_reg_wr_queue_fifo #(.WIDTH(DATA_WIDTH + STRB_WIDTH), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_axil_wvalid && s_axil_wready),
        .push_data ({s_axil_wstrb, s_axil_wdata}),
        .pop       (pop),
        .head      ({reg_wr_strb, reg_wr_data}),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign reg_wr_addr   = aw_head;
    assign reg_wr_en     = (state == ISSUE);
    assign s_axil_bvalid = (state == RESP);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bresp_next   = s_axil_bresp;
        timeout_next = 1'b0;
        decerr_next  = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!aw_empty && !w_empty) begin
                    if (aw_head < ADDR_LIMIT) begin
                        state_next = ISSUE;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        pop         = 1'b1;
                        state_next  = RESP;
                        bresp_next  = RESP_DECERR;
                        decerr_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Ack takes priority over an expiring count.
                if (reg_wr_ack) begin
                    pop        = 1'b1;
                    state_next = RESP;
                    bresp_next = RESP_OKAY;
                end else if ((TIMEOUT != 0) && (cnt == '0)) begin
                    pop          = 1'b1;
                    state_next   = RESP;
                    bresp_next   = RESP_SLVERR;
                    timeout_next = 1'b1;
                end else if (!reg_wr_wait && (cnt != '0)) begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                if (s_axil_bready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            s_axil_bresp <= RESP_OKAY;
            stat_timeout <= 1'b0;
            stat_decerr  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            s_axil_bresp <= bresp_next;
            stat_timeout <= timeout_next;
            stat_decerr  <= decerr_next;
        end
    end
endmodule

// File: tb/tb_axil_reg_wr_queue.sv
// Directed bench for axil_reg_wr_queue: scoreboard queues of expected register
// writes and B responses, filled as stimulus is driven and drained by a monitor.

module tb_axil_reg_wr_queue;
    localparam logic [31:0] LIMIT = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b1;
    logic [31:0] reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_en;
    logic        reg_wr_wait = 1'b0;
    logic        reg_wr_ack = 1'b0;
    logic        stat_timeout;
    logic        stat_decerr;

    axil_reg_wr_queue #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .AW_DEPTH   (4),
        .W_DEPTH    (4),
        .TIMEOUT    (4),
        .ADDR_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .reg_wr_addr    (reg_wr_addr),
        .reg_wr_data    (reg_wr_data),
        .reg_wr_strb    (reg_wr_strb),
        .reg_wr_en      (reg_wr_en),
        .reg_wr_wait    (reg_wr_wait),
        .reg_wr_ack     (reg_wr_ack),
        .stat_timeout   (stat_timeout),
        .stat_decerr    (stat_decerr)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    logic [31:0] exp_addr [$];
    logic [35:0] exp_data [$];
    logic [1:0]  exp_resp [$];

    int resp_count  = 0;
    int en_len      = 0;
    int last_en_len = 0;
    int en_rises    = 0;
    int n_tmo       = 0;
    int n_dec       = 0;
    int n_bvalid    = 0;
    int aw_first_low = -1;
    int rsp_mode    = 0;   // 0 ack at once, 1 never ack, 2 wait 10 cycles then ack
    int rsp_cyc     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register-port responder.
    always @(negedge clk) begin
        if (reg_wr_en) rsp_cyc++;
        else rsp_cyc = 0;
        case (rsp_mode)
            0: begin reg_wr_ack = reg_wr_en; reg_wr_wait = 1'b0; end
            1: begin reg_wr_ack = 1'b0;      reg_wr_wait = 1'b0; end
            default: begin
                reg_wr_wait = reg_wr_en && (rsp_cyc <= 10);
                reg_wr_ack  = reg_wr_en && (rsp_cyc > 10);
            end
        endcase
    end

    // Monitor: register writes and B responses against the scoreboard.
    always @(negedge clk) begin : mon
        logic [31:0] ea;
        logic [35:0] ed;
        logic [1:0]  er;
        if (reg_wr_en) begin
            if (en_len == 0) begin
                en_rises++;
                if (exp_addr.size() == 0 || exp_data.size() == 0) begin
                    check("wr_unexpected", 64'(exp_addr.size()), 64'd1);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("wr_addr", 64'(reg_wr_addr), 64'(ea));
                    check("wr_data", 64'({reg_wr_strb, reg_wr_data}), 64'(ed));
                end
            end
            en_len++;
        end else if (en_len != 0) begin
            last_en_len = en_len;
            en_len = 0;
        end
        if (stat_timeout) n_tmo++;
        if (stat_decerr) n_dec++;
        if (s_axil_bvalid) n_bvalid++;
        if (s_axil_bvalid && s_axil_bready) begin
            if (exp_resp.size() == 0) begin
                check("resp_unexpected", 64'(exp_resp.size()), 64'd1);
            end else begin
                er = exp_resp.pop_front();
                check("bresp", 64'(s_axil_bresp), 64'(er));
            end
            resp_count++;
        end
    end

    // Drives n AW beats at once and n W beats starting w_delay cycles later.
    task automatic stream(input int n, input logic [31:0] base, input logic [31:0] d0,
                          input logic [3:0] s0, input int w_delay, input logic [1:0] resp);
        int  na = 0;
        int  nw = 0;
        int  cyc = 0;
        bit  ar, wr;
        logic [31:0] a;
        @(posedge clk); #1;
        while ((na < n || nw < n) && cyc < 300) begin
            s_axil_awvalid = (na < n);
            s_axil_awaddr  = base + 32'(4 * na);
            s_axil_wvalid  = (nw < n) && (cyc >= w_delay);
            s_axil_wdata   = d0 + 32'(nw);
            s_axil_wstrb   = s0 ^ 4'(nw);
            @(negedge clk);
            ar = s_axil_awvalid && s_axil_awready;
            wr = s_axil_wvalid && s_axil_wready;
            if (s_axil_awvalid && !s_axil_awready && aw_first_low < 0) aw_first_low = na;
            @(posedge clk);
            if (ar) begin
                if (s_axil_awaddr < LIMIT) begin
                    exp_addr.push_back(s_axil_awaddr);
                    exp_resp.push_back(resp);
                end else begin
                    exp_resp.push_back(2'b11);
                end
                na++;
            end
            if (wr) begin
                a = base + 32'(4 * nw);
                if (a < LIMIT) exp_data.push_back({s_axil_wstrb, s_axil_wdata});
                nw++;
            end
            #1;
            cyc++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("stream_done", 64'(na + nw), 64'(2 * n));
    endtask

    task automatic wait_resp(input int target);
        for (int c = 0; c < 300 && resp_count < target; c++) @(negedge clk);
        check("resp_wait", 64'(resp_count), 64'(target));
        @(posedge clk); #1;
    endtask

    initial begin
        int snap_tmo, snap_dec, snap_rises, snap_bv;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_axil_awready), 64'd0);
        check("rst_wready", 64'(s_axil_wready), 64'd0);
        check("rst_bvalid", 64'(s_axil_bvalid), 64'd0);
        check("rst_en", 64'(reg_wr_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 64'(s_axil_awready), 64'd1);
        check("post_rst_wready", 64'(s_axil_wready), 64'd1);
        check("post_rst_bresp", 64'(s_axil_bresp), 64'd0);
        check("post_rst_stats", 64'({stat_timeout, stat_decerr}), 64'd0);

        // AW then W three cycles later, immediate ack: exact latency
        rsp_mode = 0;
        stream(1, 32'h10, 32'hA5A5_A5A5, 4'hF, 3, 2'b00);
        @(negedge clk);
        check("lat_c1_en", 64'(reg_wr_en), 64'd0);
        @(negedge clk);
        check("lat_c2_en", 64'(reg_wr_en), 64'd1);
        @(negedge clk);
        check("lat_c3_en", 64'(reg_wr_en), 64'd0);
        check("lat_c3_bvalid", 64'(s_axil_bvalid), 64'd1);
        check("lat_c3_bresp", 64'(s_axil_bresp), 64'd0);
        wait_resp(1);
        check("single_en_len", 64'(last_en_len), 64'd1);

        // Burst of 6 AWs before any W: AW FIFO fills at 4
        aw_first_low = -1;
        stream(6, 32'h20, 32'h1000_0000, 4'hF, 6, 2'b00);
        check("aw_full_after", 64'(aw_first_low), 64'd4);
        wait_resp(7);

        // Timeout with no ack and wait low
        rsp_mode = 1;
        snap_tmo = n_tmo;
        stream(1, 32'h30, 32'h3333_0000, 4'h3, 0, 2'b10);
        wait_resp(8);
        check("tmo_en_len", 64'(last_en_len), 64'd4);
        @(negedge clk);
        check("tmo_pulse", 64'(n_tmo - snap_tmo), 64'd1);
        @(posedge clk); #1;

        // Wait held 10 cycles then ack: no timeout
        rsp_mode = 2;
        snap_tmo = n_tmo;
        stream(1, 32'h34, 32'h4444_0000, 4'hC, 1, 2'b00);
        wait_resp(9);
        check("wait_en_len", 64'(last_en_len), 64'd11);
        check("wait_no_tmo", 64'(n_tmo - snap_tmo), 64'd0);

        // Out-of-range address then a normal write to 0x0
        rsp_mode = 0;
        snap_dec = n_dec;
        snap_rises = en_rises;
        stream(1, 32'h104, 32'h5555_0000, 4'hF, 0, 2'b00);
        wait_resp(10);
        @(negedge clk);
        check("dec_no_en", 64'(en_rises - snap_rises), 64'd0);
        check("dec_pulse", 64'(n_dec - snap_dec), 64'd1);
        @(posedge clk); #1;
        stream(1, 32'h0, 32'h6666_0000, 4'h5, 0, 2'b00);
        wait_resp(11);
        check("after_dec_en_len", 64'(last_en_len), 64'd1);

        // Reset during ISSUE with bready low: write dropped
        rsp_mode = 1;
        s_axil_bready = 1'b0;
        stream(1, 32'h40, 32'h7777_0000, 4'hF, 0, 2'b10);
        for (int c = 0; c < 20 && !reg_wr_en; c++) @(negedge clk);
        check("rst_issue_reached", 64'(reg_wr_en), 64'd1);
        snap_bv = n_bvalid;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_awready", 64'(s_axil_awready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_resp.delete();
        @(negedge clk);
        check("mid_rst_en_low", 64'(reg_wr_en), 64'd0);
        @(posedge clk); #1;
        s_axil_bready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_no_bvalid", 64'(n_bvalid - snap_bv), 64'd0);
        check("mid_rst_resp_count", 64'(resp_count), 64'd11);
        rsp_mode = 0;
        stream(1, 32'h44, 32'h8888_0000, 4'hA, 2, 2'b00);
        wait_resp(12);
        check("post_mid_rst_en_len", 64'(last_en_len), 64'd1);

        check("exp_resp_empty", 64'(exp_resp.size()), 64'd0);
        check("exp_wr_empty", 64'(exp_addr.size() + exp_data.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
